gshare_predictor: RTL and testbench

Synthesizable gshare direction predictor serving the same request/update protocol that the DPI predictor harness serves in simulation. It lets the core swap the software model for real RTL without changing the frontend or commit-side plumbing. The block holds a table of 2-bit saturating counters indexed by PC XOR global history. It answers each accepted prediction request one cycle later, applies commit-time training updates, and clears its table with an entry-per-cycle sweep after reset or flush.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_counter_table.sv | 34 +++
 rtl/gshare_predictor.sv | 122 ++++++++++++
 tb/tb_gshare_predictor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// Counters are 2-bit saturating: 0 strong-NT .. 3 strong-T, prediction is bit 1.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT  = 2'd0;
    localparam ctr_t CTR_WNT  = 2'd1;
    localparam ctr_t CTR_WT   = 2'd2;
    localparam ctr_t CTR_ST   = 2'd3;
    localparam ctr_t CTR_INIT = CTR_WNT;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic ctr_t sat_update(ctr_t ctr, bit taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter storage: one async read port, one synchronous write port.
// The write port either loads the init value or saturating-updates the addressed entry.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 10
) (
    input  logic                  clk_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output ctr_t                  rd_ctr_c_o,
    input  logic                  wr_en_i,
    input  logic                  wr_init_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic                  wr_taken_i
);

    localparam int unsigned DEPTH = 32'd1 << INDEX_BITS;

    ctr_t mem_q [DEPTH];
    ctr_t wr_data;

    assign rd_ctr_c_o = mem_q[rd_idx_i];

    always_comb begin
        wr_data = CTR_INIT;
        if (!wr_init_i) wr_data = sat_update(mem_q[wr_idx_i], wr_taken_i);
    end

    // No reset on storage: the init sweep establishes contents after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_idx_i] <= wr_data;
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor global history indexes 2-bit counters.
// Responds one cycle after an accepted request; trains on commit-time updates.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 10,
    parameter int unsigned HIST_BITS  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    output logic        req_ready_o,
    input  logic        req_valid_i,
    input  logic [63:0] req_pc_i,
    output logic        resp_valid_o,
    output logic        resp_taken_o,
    output logic        update_ready_o,
    input  logic        update_valid_i,
    input  logic [63:0] update_pc_i,
    input  logic        update_taken_i
);

    state_t                 state_q, state_d;
    logic [INDEX_BITS-1:0]  init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0]   ghr_q, ghr_d;
    logic                   ready_q, ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_taken_q, resp_taken_d;

    logic                   req_fire;
    logic                   upd_fire;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [INDEX_BITS-1:0]  upd_idx;
    logic                   tbl_wr_en;
    logic                   tbl_wr_init;
    logic [INDEX_BITS-1:0]  tbl_wr_idx;
    ctr_t                   rd_ctr;
    logic                   unused_pc_bits;

    assign req_idx = req_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign upd_idx = update_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);

    assign unused_pc_bits = ^{req_pc_i[63:INDEX_BITS+2], req_pc_i[1:0],
                              update_pc_i[63:INDEX_BITS+2], update_pc_i[1:0]};

    // Updates arriving with a flush are dropped; requests still get answered.
    assign req_fire = req_valid_i && ready_q;
    assign upd_fire = update_valid_i && ready_q && !flush_i;

    assign tbl_wr_init = (state_q == INIT);
    assign tbl_wr_en   = tbl_wr_init || upd_fire;
    assign tbl_wr_idx  = tbl_wr_init ? init_ptr_q : upd_idx;

    bp_counter_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_table (
        .clk_i      (clk_i),
        .rd_idx_i   (req_idx),
        .rd_ctr_c_o (rd_ctr),
        .wr_en_i    (tbl_wr_en),
        .wr_init_i  (tbl_wr_init),
        .wr_idx_i   (tbl_wr_idx),
        .wr_taken_i (update_taken_i)
    );

    // Next-state: init sweep, training history, response capture, flush override.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ghr_d        = ghr_q;
        resp_valid_d = 1'b0;
        resp_taken_d = resp_taken_q;

        if (req_fire) begin
            resp_valid_d = 1'b1;
            resp_taken_d = rd_ctr[1];
        end

        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + INDEX_BITS'(1);
                if (init_ptr_q == '1) state_d = READY;
            end
            READY: begin
                if (upd_fire) ghr_d = HIST_BITS'({ghr_q, update_taken_i});
            end
            default: state_d = INIT;
        endcase

        if (flush_i) begin
            state_d    = INIT;
            init_ptr_d = '0;
            ghr_d      = '0;
        end

        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign update_ready_o = ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_taken_o   = resp_taken_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor (INDEX_BITS=4, HIST_BITS=2): directed table,
// hand-written reset/flush sequences, and random traffic against a reference model.
module tb_gshare_predictor;

    localparam int unsigned IB      = 4;
    localparam int unsigned HB      = 2;
    localparam int          ENTRIES = 16;
    localparam int          HMOD    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_ready;
    logic        req_valid;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic        update_ready;
    logic        update_valid;
    logic [63:0] update_pc;
    logic        update_taken;

    always #5 clk = ~clk;

    gshare_predictor #(
        .INDEX_BITS (IB),
        .HIST_BITS  (HB)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .req_ready_o    (req_ready),
        .req_valid_i    (req_valid),
        .req_pc_i       (req_pc),
        .resp_valid_o   (resp_valid),
        .resp_taken_o   (resp_taken),
        .update_ready_o (update_ready),
        .update_valid_i (update_valid),
        .update_pc_i    (update_pc),
        .update_taken_i (update_taken)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: counters as plain ints, history as an int modulo 2^HB.
    int m_tab [ENTRIES];
    bit m_ready;
    int m_init_left;
    int m_ghr;
    bit m_v;
    bit m_t;

    typedef struct {
        bit          reinit;
        bit          rv;
        logic [63:0] rpc;
        bit          uv;
        logic [63:0] upc;
        bit          ut;
        bit          ev;
        bit          et;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit reinit, bit rv, logic [63:0] rpc, bit uv,
                                logic [63:0] upc, bit ut, bit ev, bit et);
        vec_t v;
        v.reinit = reinit; v.rv = rv; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.ut = ut;
        v.ev = ev; v.et = et;
        return v;
    endfunction

    function automatic int midx(logic [63:0] pc);
        return int'((pc >> 2) % 64'd16) ^ m_ghr;
    endfunction

    task automatic chk(string name, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready     = 1'b0;
        m_init_left = ENTRIES;
        m_ghr       = 0;
        m_v         = 1'b0;
        m_t         = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit ready_pre;
        int i;
        ready_pre = m_ready;
        m_v = req_valid && ready_pre;
        if (m_v) m_t = (m_tab[midx(req_pc)] >= 2);
        if (ready_pre && update_valid && !flush) begin
            i = midx(update_pc);
            if (update_taken) m_tab[i] = (m_tab[i] < 3) ? m_tab[i] + 1 : 3;
            else              m_tab[i] = (m_tab[i] > 0) ? m_tab[i] - 1 : 0;
            m_ghr = (m_ghr * 2 + int'(update_taken)) % HMOD;
        end
        if (!ready_pre) begin
            m_init_left--;
            if (m_init_left == 0) begin
                foreach (m_tab[k]) m_tab[k] = 1;
                m_ready = 1'b1;
            end
        end
        if (flush) begin
            m_ready     = 1'b0;
            m_init_left = ENTRIES;
            m_ghr       = 0;
        end
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_pc       = '0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("req_ready",    req_ready,    m_ready);
        chk("update_ready", update_ready, m_ready);
        chk("resp_valid",   resp_valid,   m_v);
        chk("resp_taken",   resp_taken,   m_t);
    endtask

    // Assert reset away from the clock edge and check outputs drop immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_req_ready",    req_ready,    1'b0);
        chk("rst_update_ready", update_ready, 1'b0);
        chk("rst_resp_valid",   resp_valid,   1'b0);
        chk("rst_resp_taken",   resp_taken,   1'b0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic reinit();
        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            cycle();
            chk("sweep_ready", req_ready, i == ENTRIES - 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        foreach (m_tab[k]) m_tab[k] = 1;
        model_reset();
        #12;

        vecs.push_back(mk(1, 1, 64'h40, 0, 64'h0,  0, 1, 0));
        vecs.push_back(mk(1, 0, 64'h0,  1, 64'h10, 1, 0, 0));
        vecs.push_back(mk(0, 1, 64'h14, 0, 64'h0,  0, 1, 1));
        vecs.push_back(mk(1, 0, 64'h0,  1, 64'h0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  1, 64'h0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  1, 64'h0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  1, 64'h0,  1, 0, 0));
        vecs.push_back(mk(0, 1, 64'h4,  0, 64'h0,  0, 1, 0));
        vecs.push_back(mk(1, 1, 64'h10, 1, 64'h10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 64'h14, 0, 64'h0,  0, 1, 1));

        foreach (vecs[n]) begin
            if (vecs[n].reinit) reinit();
            req_valid    = vecs[n].rv;
            req_pc       = vecs[n].rpc;
            update_valid = vecs[n].uv;
            update_pc    = vecs[n].upc;
            update_taken = vecs[n].ut;
            cycle();
            chk("tbl_resp_valid", resp_valid, vecs[n].ev);
            chk("tbl_resp_taken", resp_taken, vecs[n].et);
            clear_inputs();
            cycle();
            chk("tbl_pulse_end", resp_valid, 1'b0);
        end

        // Reset while READY with resp_taken=1: outputs must drop before any edge.
        chk("pre_reset_taken", resp_taken, 1'b1);
        reinit();

        // Reset mid-sweep: the full sweep must repeat afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        reinit();

        // Flush after training: flush-cycle request sees pre-flush table.
        update_valid = 1'b1; update_pc = 64'h10; update_taken = 1'b1;
        cycle();
        clear_inputs();
        flush = 1'b1;
        req_valid = 1'b1; req_pc = 64'h14;
        update_valid = 1'b1; update_pc = 64'h14; update_taken = 1'b1;
        cycle();
        chk("flush_cycle_valid", resp_valid, 1'b1);
        chk("flush_cycle_taken", resp_taken, 1'b1);
        clear_inputs();
        req_valid = 1'b1; req_pc = 64'h10;
        for (int i = 0; i < ENTRIES; i++) begin
            cycle();
            chk("flush_sweep_ready", req_ready, i == ENTRIES - 1);
            chk("flush_sweep_nresp", resp_valid, 1'b0);
        end
        cycle();
        chk("post_flush_valid", resp_valid, 1'b1);
        chk("post_flush_taken", resp_taken, 1'b0);
        clear_inputs();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            req_valid    = ($urandom_range(0, 3) != 0);
            req_pc       = {$urandom, $urandom};
            update_valid = ($urandom_range(0, 2) != 0);
            update_pc    = {$urandom, $urandom};
            update_taken = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clear_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
